// File: rtl/riscv_pkg.sv
// riscv_pkg: shared funct3 size/sign constants, MEM-stage FSM state and write-back payload type
package riscv_pkg;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_D = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100, F3_HU = 3'b101, F3_WU = 3'b110;
  typedef enum logic {IDLE, WAIT} mem_state_t;
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        misalign;
    logic [63:0] read_data;
    logic [63:0] result;
    logic [4:0]  rd;
  } wb_t;
  function automatic logic [1:0] f3_lg_size(input logic [2:0] f3);
    return f3[1:0];
  endfunction
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [2:0] off);
    logic [3:0] mask;
    mask = (4'd1 << f3_lg_size(f3)) - 4'd1;
    return (off & mask[2:0]) == 3'd0;
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: single-outstanding req/ack data-memory port (master = MEM stage, slave = memory)
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_rdata, mem_ack);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_rdata, mem_ack);
endinterface

// File: rtl/load_align.sv
// load_align: shift read doubleword down to the accessed byte offset and sign/zero-extend by funct3
module load_align
  import riscv_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);
  logic [63:0] sh;
  assign sh = rdata >> {off, 3'b000};
  always_comb
    data = funct3 == F3_B  ? {{56{sh[7]}}, sh[7:0]} :
           funct3 == F3_H  ? {{48{sh[15]}}, sh[15:0]} :
           funct3 == F3_W  ? {{32{sh[31]}}, sh[31:0]} :
           funct3 == F3_BU ? {56'd0, sh[7:0]} :
           funct3 == F3_HU ? {48'd0, sh[15:0]} :
           funct3 == F3_WU ? {32'd0, sh[31:0]} : sh;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RISC-V MEM stage - aligned loads/stores over req/ack port, branch resolve, MEM/WB register
module mem_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        RegWrite_S,
  input  logic        MemtoReg_S,
  input  logic        MemRead_S,
  input  logic        MemWrite_S,
  input  logic        Branch_S,
  input  logic        ZERO_S,
  input  logic [63:0] Result_S,
  input  logic [63:0] Write_Data_Mem_S,
  input  logic [63:0] Branch_Address_S,
  input  logic [3:0]  Funct_S,
  input  logic [4:0]  RD_S,
  mem_stage_if.master mem,
  output logic        stall,
  output logic        PCSrc,
  output logic [63:0] Branch_Target,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [63:0] wb_Read_Data,
  output logic [63:0] wb_Result,
  output logic [4:0]  wb_RD,
  output logic        misalign
);
  mem_state_t  state_q, state_d;
  logic        req_q, req_d, we_q, we_d, rw_q, rw_d, m2r_q, m2r_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, res_q, res_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [2:0]  off_q, off_d, f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  wb_t         wb_q, wb_d;
  logic [2:0]  off, f3;
  logic        is_mem, ok;
  logic [15:0] strb_w;
  logic [63:0] ld_data;
  logic        unused_funct7;
  assign unused_funct7 = Funct_S[3];
  assign off = Result_S[2:0];
  assign f3 = Funct_S[2:0];
  assign is_mem = in_valid & (MemRead_S | MemWrite_S);
  assign ok = f3_aligned(f3, off);
  assign strb_w = ((16'd1 << (5'd1 << f3_lg_size(f3))) - 16'd1) << off;
  load_align u_load_align (.rdata(mem.mem_rdata), .off(off_q), .funct3(f3_q), .data(ld_data));
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    off_d = off_q;
    f3_d = f3_q;
    rw_d = rw_q;
    m2r_d = m2r_q;
    rd_d = rd_q;
    res_d = res_q;
    wb_d = wb_q;
    wb_d.valid = 1'b0;
    wb_d.misalign = 1'b0;
    if (state_q == IDLE) begin
      // Aligned memory ops defer write-back to the ack; misaligned ones retire now with no register write.
      wb_d = '{valid: in_valid & ~(is_mem & ok), regwrite: in_valid & RegWrite_S & ~is_mem,
               memtoreg: MemtoReg_S & ~is_mem, misalign: is_mem & ~ok, read_data: 64'd0,
               result: Result_S, rd: RD_S};
      if (is_mem & ok) begin
        state_d = WAIT;
        req_d = 1'b1;
        we_d = MemWrite_S;
        addr_d = {Result_S[63:3], 3'b000};
        wdata_d = Write_Data_Mem_S << {off, 3'b000};
        wstrb_d = MemWrite_S ? strb_w[7:0] : 8'd0;
        off_d = off;
        f3_d = f3;
        rw_d = RegWrite_S;
        m2r_d = MemtoReg_S;
        rd_d = RD_S;
        res_d = Result_S;
      end
    end else if (mem.mem_ack) begin
      state_d = IDLE;
      req_d = 1'b0;
      wb_d = '{valid: 1'b1, regwrite: rw_q, memtoreg: m2r_q, misalign: 1'b0,
               read_data: we_q ? 64'd0 : ld_data, result: res_q, rd: rd_q};
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      off_q <= '0;
      f3_q <= '0;
      rw_q <= 1'b0;
      m2r_q <= 1'b0;
      rd_q <= '0;
      res_q <= '0;
      wb_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      off_q <= off_d;
      f3_q <= f3_d;
      rw_q <= rw_d;
      m2r_q <= m2r_d;
      rd_q <= rd_d;
      res_q <= res_d;
      wb_q <= wb_d;
    end
  assign mem.mem_req = req_q;
  assign mem.mem_we = we_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;
  assign stall = state_q == WAIT;
  assign PCSrc = in_valid & Branch_S & ZERO_S & (state_q == IDLE);
  assign Branch_Target = Branch_Address_S;
  assign wb_valid = wb_q.valid;
  assign wb_RegWrite = wb_q.regwrite;
  assign wb_MemtoReg = wb_q.memtoreg;
  assign wb_Read_Data = wb_q.read_data;
  assign wb_Result = wb_q.result;
  assign wb_RD = wb_q.rd;
  assign misalign = wb_q.misalign;
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 64-bit pipelined RISC-V core. It sits directly downstream of the EX/MEM pipeline register and consumes its stored outputs. It performs byte/half/word/double loads and stores over a single-outstanding req/ack data-memory port, resolves the branch decision, and registers the MEM/WB payload for write-back. While a memory access is outstanding it stalls the upstream pipeline.

## Interface
- No parameters. Data width is fixed at 64 bits and the register index at 5 bits.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  the EX/MEM slot holds a real instruction (0 = bubble).
- RegWrite_S, MemtoReg_S, MemRead_S, MemWrite_S, Branch_S, ZERO_S  in  1 each  control signals from EX/MEM.
- Result_S  in  64  ALU result; the byte address for memory operations.
- Write_Data_Mem_S  in  64  store data, right-aligned.
- Branch_Address_S  in  64  branch target.
- Funct_S  in  4  {funct7[5], funct3}; only funct3 is used here.
- RD_S  in  5  destination register.
- mem_req  out  1  memory request, held high until acknowledged.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  64  doubleword-aligned address, {Result_S[63:3], 3'b000}.
- mem_wdata  out  64  store data shifted into its byte lanes.
- mem_wstrb  out  8  byte-enable mask for stores; 0 for loads.
- mem_rdata  in  64  read data; valid only in a cycle where mem_ack is high.
- mem_ack  in  1  one-cycle completion pulse.
- stall  out  1  upstream must hold EX/MEM; registered.
- PCSrc  out  1  take the branch (combinational).
- Branch_Target  out  64  equal to Branch_Address_S.
- wb_valid, wb_RegWrite, wb_MemtoReg  out  1 each  MEM/WB control.
- wb_Read_Data, wb_Result  out  64 each  load result and ALU result.
- wb_RD  out  5  destination register.
- misalign  out  1  one-cycle flag: the offending access was dropped.

## Operation
- FSM has two states: IDLE and WAIT. stall = (state == WAIT).
- In IDLE, the input is consumed at every edge.
  - A memory operation is in_valid & (MemRead_S | MemWrite_S).
- funct3 encodings:
  - 000 = B, 001 = H, 010 = W, 011 = D.
  - 100 = BU, 101 = HU, 110 = WU.
  - 111 is treated as D.
- Access size is 1, 2, 4 or 8 bytes. off = Result_S[2:0].
- Alignment rule: off must be a multiple of the access size.
- Aligned memory op in IDLE:
  - Latch addr, we, strb, wdata, RD and control.
  - Set mem_req = 1 and go to WAIT.
  - wb_valid = 0 on the next cycle.
- Store lanes:
  - mem_wdata = Write_Data_Mem_S << (8 * off).
  - mem_wstrb = ((1 << size) - 1) << off.
- Load extraction: shift mem_rdata >> (8 * off), then sign-extend or zero-extend according to funct3.
- WAIT with mem_ack = 1:
  - mem_req drops to 0 and the FSM returns to IDLE.
  - MEM/WB outputs load: wb_valid = 1, and wb_Read_Data is the extracted value (0 for a store).
  - The store's wb_RegWrite is passed through unchanged (normally 0).
- WAIT with mem_ack = 0: hold all request outputs stable; wb_valid = 0.
- Misaligned memory op in IDLE:
  - No request is issued.
  - Next cycle: misalign = 1, wb_valid = 1, wb_RegWrite = 0.
- Non-memory valid instruction in IDLE: next cycle wb_valid = 1 with wb_Result = Result_S and control/RD copied.
- in_valid = 0 in IDLE: next cycle wb_valid = 0.
- PCSrc = in_valid & Branch_S & ZERO_S & (state == IDLE).
- mem_ack while in IDLE is ignored.

## Timing
- Reset (asynchronous) values:
  - state = IDLE.
  - mem_req, mem_we, mem_wstrb, stall, wb_valid, wb_RegWrite, wb_MemtoReg, misalign = 0.
  - All data outputs = 0.
- Non-memory instruction: 1 cycle input-to-MEM/WB; throughput 1 per cycle.
- Memory operation: the request is visible the cycle after capture. Write-back follows the edge that samples mem_ack. Occupancy = 1 + number of WAIT cycles.
- Reset asserted mid-WAIT: return to IDLE immediately and drop mem_req. A late mem_ack is ignored, and the aborted access produces no write-back.

## Structure
- The shared package riscv_pkg holds:
  - funct3 size/sign constants.
  - The mem_state_t enum {IDLE, WAIT}.
- Sub-module load_align (combinational): inputs rdata, off, funct3; output is the extended 64-bit value.

## Test plan
- ALU op: Result_S = 0x1234, RegWrite = 1, RD = 5 → next cycle wb_valid = 1, wb_Result = 0x1234, wb_RD = 5, stall = 0.
- SB: Result_S = 0x1003, data = 0xAB, ack after 3 cycles → mem_addr = 0x1000, wstrb = 0x08, wdata[31:24] = 0xAB; stall high for 3 cycles, then wb_valid.
- LH: off = 2, rdata = 0x0000_0000_8001_0000 → wb_Read_Data = 0xFFFF_FFFF_FFFF_8001; LHU gives 0x8001.
- LW at Result_S = 0x1002 → misalign = 1, mem_req never asserted, wb_RegWrite = 0.
- Branch_S = ZERO_S = 1 in IDLE → PCSrc = 1. Same inputs during WAIT → PCSrc = 0.
- reset_n low mid-WAIT, then an ack pulse → mem_req = 0 at once, no wb_valid produced, state IDLE.
